// File: rtl/std_cache_pkg.sv
// Shared definitions for the D-cache error monitor: config/exception types,
// register indices and STATUS/CTRL/CLEAR bit positions.
package std_cache_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64};

    // Fields are sized for the widest XLEN; narrower cores leave upper bits 0.
    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
    } errmon_ue_rec_t;

    localparam logic [3:0] ERRMON_CNT0       = 4'd0;
    localparam logic [3:0] ERRMON_CNT5       = 4'd5;
    localparam logic [3:0] ERRMON_STATUS     = 4'd6;
    localparam logic [3:0] ERRMON_THRESH     = 4'd7;
    localparam logic [3:0] ERRMON_CTRL       = 4'd8;
    localparam logic [3:0] ERRMON_CLEAR      = 4'd9;
    localparam logic [3:0] ERRMON_UE_CAUSE   = 4'd10;
    localparam logic [3:0] ERRMON_UE_TVAL_LO = 4'd11;
    localparam logic [3:0] ERRMON_UE_TVAL_HI = 4'd12;

    localparam int unsigned ERRMON_ST_UE_VALID   = 0;
    localparam int unsigned ERRMON_ST_UE_OVERRUN = 1;
    localparam int unsigned ERRMON_ST_SAT_LSB    = 8;
    localparam int unsigned ERRMON_ST_IRQ        = 16;
    localparam int unsigned ERRMON_ST_OCC_LSB    = 24;

    localparam int unsigned ERRMON_CTRL_CE_EN = 0;
    localparam int unsigned ERRMON_CTRL_UE_EN = 1;

    localparam int unsigned ERRMON_CLR_UE  = 0;
    localparam int unsigned ERRMON_CLR_SAT = 1;
    localparam int unsigned ERRMON_CLR_CNT = 2;

    localparam int unsigned ERRMON_UE_FIFO_DEPTH = 4;

endpackage

// File: rtl/std_nbdcache_err_fifo.sv
// Small FIFO of uncorrectable-error records; flush wins over stored entries,
// but a push in the flush cycle is kept. Depth must be a power of two.
module std_nbdcache_err_fifo
    import std_cache_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  errmon_ue_rec_t               data_i,
    input  logic                         pop_i,
    output errmon_ue_rec_t               data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned UW = $clog2(Depth + 1);

    errmon_ue_rec_t  mem_q [Depth];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [UW-1:0]   usage_q;
    logic            do_push, do_pop;

    assign full_o  = (usage_q == UW'(Depth));
    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push is accepted when full.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= AW'(push_i);
            rd_ptr_q <= '0;
            usage_q  <= UW'(push_i);
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            usage_q <= usage_q + UW'(do_push) - UW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            if (push_i) mem_q[0] <= data_i;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/std_nbdcache_err_monitor.sv
// D-cache ECC error monitor: saturating event counters, UE capture, threshold irq.
// Optional DCACHE_ERR_MON_FIFO_EN turns the single UE record into a 4-deep FIFO.
module std_nbdcache_err_monitor
    import std_cache_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg   = cva6_cfg_empty,
    parameter int unsigned NumEvents = 6,
    parameter int unsigned CntWidth  = 32,
    parameter int unsigned CeIdx     = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumEvents-1:0] counters_i,
    input  exception_t           uncorrectable_ex_i,
    input  logic                 reg_req_i,
    input  logic                 reg_we_i,
    input  logic [3:0]           reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    output logic                 reg_gnt_o,
    output logic                 reg_rvalid_o,
    output logic [31:0]          reg_rdata_o,
    output logic                 irq_o
);
    localparam logic [CntWidth-1:0] CntMax = '1;

    logic [CntWidth-1:0] cnt_q [NumEvents];
    logic [31:0]         cnt_ext [NumEvents];
    logic [NumEvents-1:0] sat_q;
    logic [31:0]         thresh_q;
    logic                irq_ce_en_q, irq_ue_en_q;
    logic                rvalid_q, irq_q, irq_d;
    logic [31:0]         rdata_q, rd_data, status;
    logic                wr_en, rd_en, clr_ue, clr_sat, clr_cnt;
    logic                ue_valid, ue_overrun;
    errmon_ue_rec_t      ue_rec, ue_new;
    logic                unused_cause_hi;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

    assign wr_en   = reg_req_i & reg_we_i;
    assign rd_en   = reg_req_i & ~reg_we_i;
    assign clr_ue  = wr_en & (reg_addr_i == ERRMON_CLEAR) & reg_wdata_i[ERRMON_CLR_UE];
    assign clr_sat = wr_en & (reg_addr_i == ERRMON_CLEAR) & reg_wdata_i[ERRMON_CLR_SAT];
    assign clr_cnt = wr_en & (reg_addr_i == ERRMON_CLEAR) & reg_wdata_i[ERRMON_CLR_CNT];
    assign ue_new  = {uncorrectable_ex_i.cause, uncorrectable_ex_i.tval};
    assign unused_cause_hi = ^ue_rec.cause[63:32];

    // Software writes and counter clears win over a same-cycle event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumEvents; i++) cnt_q[i] <= '0;
            sat_q <= '0;
        end else begin
            if (clr_sat) sat_q <= '0;
            for (int i = 0; i < NumEvents; i++) begin
                if (wr_en && reg_addr_i == 4'(i)) begin
                    cnt_q[i] <= reg_wdata_i[CntWidth-1:0];
                end else if (clr_cnt) begin
                    cnt_q[i] <= '0;
                end else if (counters_i[i]) begin
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                    if (cnt_q[i] >= CntMax - 1'b1) sat_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thresh_q    <= '0;
            irq_ce_en_q <= 1'b0;
            irq_ue_en_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_en && reg_addr_i == ERRMON_THRESH) thresh_q <= reg_wdata_i;
            if (wr_en && reg_addr_i == ERRMON_CTRL) begin
                irq_ce_en_q <= reg_wdata_i[ERRMON_CTRL_CE_EN];
                irq_ue_en_q <= reg_wdata_i[ERRMON_CTRL_UE_EN];
            end
            rvalid_q <= rd_en;
            if (rd_en) rdata_q <= rd_data;
            irq_q <= irq_d;
        end
    end

`ifdef DCACHE_ERR_MON_FIFO_EN
    localparam int unsigned OccW = $clog2(ERRMON_UE_FIFO_DEPTH + 1);

    logic            fifo_full, fifo_empty, fifo_pop, ue_overrun_q;
    logic [OccW-1:0] ue_occ;

    // Reading TVAL_HI consumes the head record.
    assign fifo_pop = rd_en & (reg_addr_i == ERRMON_UE_TVAL_HI) & ~fifo_empty;

    std_nbdcache_err_fifo #(
        .Depth (ERRMON_UE_FIFO_DEPTH)
    ) i_ue_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clr_ue),
        .push_i  (uncorrectable_ex_i.valid),
        .data_i  (ue_new),
        .pop_i   (fifo_pop),
        .data_o  (ue_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (ue_occ)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ue_overrun_q <= 1'b0;
        end else if (clr_ue) begin
            ue_overrun_q <= 1'b0;
        end else if (uncorrectable_ex_i.valid && fifo_full && !fifo_pop) begin
            ue_overrun_q <= 1'b1;
        end
    end

    assign ue_valid   = ~fifo_empty;
    assign ue_overrun = ue_overrun_q;
`else
    logic           ue_valid_q, ue_overrun_q;
    errmon_ue_rec_t ue_rec_q;

    // A UE arriving with CLEAR replaces the record instead of being an overrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ue_valid_q   <= 1'b0;
            ue_overrun_q <= 1'b0;
            ue_rec_q     <= '0;
        end else if (uncorrectable_ex_i.valid) begin
            ue_valid_q   <= 1'b1;
            ue_overrun_q <= clr_ue ? 1'b0 : (ue_overrun_q | ue_valid_q);
            if (!ue_valid_q || clr_ue) ue_rec_q <= ue_new;
        end else if (clr_ue) begin
            ue_valid_q   <= 1'b0;
            ue_overrun_q <= 1'b0;
        end
    end

    assign ue_valid   = ue_valid_q;
    assign ue_overrun = ue_overrun_q;
    assign ue_rec     = ue_rec_q;
`endif

    always_comb begin
        for (int i = 0; i < NumEvents; i++) begin
            cnt_ext[i] = '0;
            cnt_ext[i][CntWidth-1:0] = cnt_q[i];
        end
    end

    assign irq_d = (irq_ce_en_q & (thresh_q != '0) & (cnt_ext[CeIdx] >= thresh_q))
                 | (irq_ue_en_q & ue_valid);

    always_comb begin
        status = '0;
        status[ERRMON_ST_UE_VALID]   = ue_valid;
        status[ERRMON_ST_UE_OVERRUN] = ue_overrun;
        for (int i = 0; i < NumEvents && i < 6; i++) status[ERRMON_ST_SAT_LSB+i] = sat_q[i];
        status[ERRMON_ST_IRQ] = irq_q;
`ifdef DCACHE_ERR_MON_FIFO_EN
        status[ERRMON_ST_OCC_LSB +: OccW] = ue_occ;
`endif
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NumEvents; i++) begin
            if (reg_addr_i == 4'(i)) rd_data = cnt_ext[i];
        end
        case (reg_addr_i)
            ERRMON_STATUS:     rd_data = status;
            ERRMON_THRESH:     rd_data = thresh_q;
            ERRMON_CTRL: begin
                rd_data[ERRMON_CTRL_CE_EN] = irq_ce_en_q;
                rd_data[ERRMON_CTRL_UE_EN] = irq_ue_en_q;
            end
            ERRMON_UE_CAUSE:   rd_data = ue_rec.cause[31:0];
            ERRMON_UE_TVAL_LO: rd_data = ue_rec.tval[31:0];
            ERRMON_UE_TVAL_HI: rd_data = (CVA6Cfg.XLEN > 32) ? ue_rec.tval[63:32] : 32'h0;
            default: ;
        endcase
    end

    assign reg_gnt_o    = reg_req_i;
    assign reg_rvalid_o = rvalid_q;
    assign reg_rdata_o  = rdata_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_std_nbdcache_err_monitor.sv
// Directed bench for std_nbdcache_err_monitor; a second instance with 4-bit
// counters shares all stimulus and is checked for saturation behaviour.
module tb_std_nbdcache_err_monitor;
    import std_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  counters;
    exception_t  ue;
    logic        req, we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        gnt, rvalid, irq;
    logic [31:0] rdata;
    logic        gnt4, rvalid4, irq4;
    logic [31:0] rdata4;

    int tests = 0;
    int fails = 0;

    logic [31:0] d, d4;
    logic        rv;

    always #5 clk = ~clk;

    std_nbdcache_err_monitor #(.NumEvents(6), .CntWidth(32), .CeIdx(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .counters_i(counters), .uncorrectable_ex_i(ue),
        .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_gnt_o(gnt), .reg_rvalid_o(rvalid), .reg_rdata_o(rdata), .irq_o(irq)
    );

    std_nbdcache_err_monitor #(.NumEvents(6), .CntWidth(4), .CeIdx(0)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .counters_i(counters), .uncorrectable_ex_i(ue),
        .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_gnt_o(gnt4), .reg_rvalid_o(rvalid4), .reg_rdata_o(rdata4), .irq_o(irq4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = v;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] r, output logic [31:0] r4,
                            output logic valid);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        valid = rvalid; r = rdata; r4 = rdata4;
        req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; counters = '0; ue = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_rvalid", {31'b0, rvalid}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;

        // Every index reads zero after reset, rvalid one cycle after request
        for (int a = 0; a <= 12; a++) begin
            reg_read(4'(a), d, d4, rv);
            check($sformatf("reset_rvalid_idx%0d", a), {31'b0, rv}, 32'h1);
            check($sformatf("reset_data_idx%0d", a), d, 32'h0);
        end
        check("reset_irq_after_reads", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("rvalid_idle", {31'b0, rvalid}, 32'h0);
        req = 1'b1; we = 1'b0; #1;
        check("gnt_comb", {31'b0, gnt}, 32'h1);
        req = 1'b0;

        // Ten cycles of events 0 and 2
        @(negedge clk); counters = 6'b000101;
        repeat (10) @(negedge clk);
        counters = '0;
        reg_read(4'd0, d, d4, rv); check("cnt0_10", d, 32'd10);
        reg_read(4'd1, d, d4, rv); check("cnt1_0", d, 32'd0);
        reg_read(4'd2, d, d4, rv); check("cnt2_10", d, 32'd10);
        reg_read(4'd3, d, d4, rv); check("cnt3_0", d, 32'd0);
        reg_read(4'd5, d, d4, rv); check("cnt5_0", d, 32'd0);

        // Saturation on the 4-bit instance
        @(negedge clk); counters = 6'b001000;
        repeat (20) @(negedge clk);
        counters = '0;
        reg_read(4'd3, d, d4, rv);
        check("cnt3_wide_20", d, 32'd20);
        check("cnt3_sat_15", d4, 32'd15);
        reg_read(ERRMON_STATUS, d, d4, rv);
        check("status_sat3", d4, 32'h0000_0800);
        check("status_wide_nosat", d, 32'h0);
        reg_write(ERRMON_CLEAR, 32'h2);
        check("write_no_rvalid", {31'b0, rvalid}, 32'h0);
        reg_read(ERRMON_STATUS, d, d4, rv);
        check("status_sat_cleared", d4, 32'h0);
        reg_read(4'd3, d, d4, rv);
        check("cnt3_kept_15", d4, 32'd15);

        // Threshold interrupt on event 0
        reg_write(ERRMON_CLEAR, 32'h4);
        reg_write(ERRMON_THRESH, 32'd3);
        reg_write(ERRMON_CTRL, 32'h1);
        reg_read(ERRMON_THRESH, d, d4, rv); check("thresh_rb", d, 32'd3);
        reg_read(ERRMON_CTRL, d, d4, rv); check("ctrl_rb", d, 32'h1);
        @(negedge clk); counters = 6'b000001;
        repeat (3) @(negedge clk);
        counters = '0;
        check("irq_not_yet", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise", {31'b0, irq}, 32'h1);
        check("irq_rise_dut4", {31'b0, irq4}, 32'h1);
        reg_read(ERRMON_STATUS, d, d4, rv);
        check("status_irq", d, 32'h0001_0000);
        reg_write(ERRMON_CLEAR, 32'h4);
        check("irq_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_fall", {31'b0, irq}, 32'h0);
        reg_write(ERRMON_CTRL, 32'h0);

        // Two uncorrectable errors: first record kept, overrun flagged
        @(negedge clk);
        ue.valid = 1'b1; ue.cause = 64'hABCD_0000_0000_000D; ue.tval = 64'h0000_0012_8000_1040;
        @(negedge clk);
        ue.cause = 64'd7; ue.tval = 64'h2000;
        @(negedge clk);
        ue.valid = 1'b0;
        reg_read(ERRMON_STATUS, d, d4, rv); check("status_ue_overrun", d, 32'h3);
        reg_read(ERRMON_UE_CAUSE, d, d4, rv); check("ue_cause", d, 32'hD);
        reg_read(ERRMON_UE_TVAL_LO, d, d4, rv); check("ue_tval_lo", d, 32'h8000_1040);
        reg_read(ERRMON_UE_TVAL_HI, d, d4, rv); check("ue_tval_hi", d, 32'h12);
        check("irq_ue_disabled", {31'b0, irq}, 32'h0);
        reg_write(ERRMON_CTRL, 32'h2);
        check("irq_ue_pending", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_ue_rise", {31'b0, irq}, 32'h1);

        // CLEAR together with a new UE: new record captured, overrun dropped
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = ERRMON_CLEAR; wdata = 32'h1;
        ue.valid = 1'b1; ue.cause = 64'd2; ue.tval = 64'h3000;
        @(negedge clk);
        req = 1'b0; we = 1'b0; ue.valid = 1'b0;
        reg_read(ERRMON_STATUS, d, d4, rv); check("status_clr_and_ue", d, 32'h0001_0001);
        reg_read(ERRMON_UE_TVAL_LO, d, d4, rv); check("ue_tval_new", d, 32'h3000);
        reg_write(ERRMON_CLEAR, 32'h1);
        @(negedge clk);
        check("irq_ue_fall", {31'b0, irq}, 32'h0);
        reg_read(ERRMON_STATUS, d, d4, rv); check("status_ue_cleared", d, 32'h0);

        // Software write beats a same-cycle event
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd1; wdata = 32'h55; counters = 6'b000010;
        @(negedge clk);
        req = 1'b0; we = 1'b0; counters = '0;
        reg_read(4'd1, d, d4, rv); check("cnt1_write_wins", d, 32'h55);
        reg_read(4'd13, d, d4, rv); check("unmapped_13", d, 32'h0);

        // Reset in the middle of a read drops the pending rvalid
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 4'd1;
        @(posedge clk); #2;
        check("mid_rvalid_before", {31'b0, rvalid}, 32'h1);
        rst_n = 1'b0; #1;
        check("mid_rvalid_dropped", {31'b0, rvalid}, 32'h0);
        check("mid_rdata_cleared", rdata, 32'h0);
        req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        reg_read(4'd1, d, d4, rv); check("cnt1_after_reset", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
